// File: rtl/zx81_tape_pkg.sv
// Shared types and default timing for the ZX81 cassette SAVE capture path.
// All tick constants are in ce_3m25 periods.
package zx81_tape_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_GAP
  } state_e;

  localparam int BUF_DEPTH     = 16384;
  localparam int PULSE_MIN_DEF = 64;
  localparam int GAP_BIT_DEF   = 2000;
  localparam int GAP_END_DEF   = 32500;
  localparam int ZERO_MAX_DEF  = 6;
  localparam int ONE_MAX_DEF   = 12;

endpackage

// File: rtl/zx81_tape_saver_buf.sv
// Simple dual-port capture buffer: one write port, one registered read port.
// A same-address read and write in one cycle returns the old contents.
module zx81_tape_saver_buf #(
  parameter int AW = 14
) (
  input  logic          clk_sys,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_dat_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_dat_o
);

  logic [7:0] mem_q [2**AW];

  always_ff @(posedge clk_sys) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_dat_i;
    rd_dat_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/zx81_tape_saver.sv
// Decodes the ZX81 SAVE pulse stream on MIC into bytes held in a buffer for .p upload.
// Edges accepted 2 clk + PULSE_MIN ticks after MIC moves; bytes land the cycle after the 8th bit.
module zx81_tape_saver
  import zx81_tape_pkg::*;
#(
  parameter int PULSE_MIN = PULSE_MIN_DEF,
  parameter int GAP_BIT   = GAP_BIT_DEF,
  parameter int GAP_END   = GAP_END_DEF,
  parameter int ZERO_MAX  = ZERO_MAX_DEF,
  parameter int ONE_MAX   = ONE_MAX_DEF,
  parameter int DEPTH     = BUF_DEPTH
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_3m25,
  input  logic        mic,
  input  logic        arm,
  input  logic        strip_name,
  input  logic [13:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic [13:0] save_size,
  output logic        save_active,
  output logic        save_done,
  output logic        save_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0]   PMIN_M1  = 16'(PULSE_MIN - 1);
  localparam logic [15:0]   GAPB_C   = 16'(GAP_BIT);
  localparam logic [15:0]   GAPE_C   = 16'(GAP_END);
  localparam logic [3:0]    ZMAX_C   = 4'(ZERO_MAX);
  localparam logic [3:0]    OMAX_C   = 4'(ONE_MAX);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   WPTR_ONE = (AW+1)'(1);
  localparam logic [13:0]   SIZE_SAT = 14'(DEPTH - 1);

  logic          mic_s1_q, mic_s2_q, lvl_q;
  logic [15:0]   stab_q, phase_q;
  logic          acc_w, rise_w, fall_w;

  state_e        state_q;
  logic [3:0]    pulse_q;
  logic [7:0]    sr_q;
  logic [2:0]    bitcnt_q;
  logic [AW:0]   wptr_q;
  logic          name_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [7:0]    wr_dat_q;
  logic          bit_ok_w, bit_val_w;
  logic [7:0]    byte_d;

  // A new level is taken only once it has held for PULSE_MIN consecutive ticks.
  assign acc_w  = ce_3m25 && (mic_s2_q != lvl_q) && (stab_q >= PMIN_M1);
  assign rise_w = acc_w && !lvl_q;
  assign fall_w = acc_w && lvl_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mic_s1_q <= 1'b0;
      mic_s2_q <= 1'b0;
      lvl_q    <= 1'b0;
      stab_q   <= '0;
      phase_q  <= '0;
    end else begin
      mic_s1_q <= mic;
      mic_s2_q <= mic_s1_q;
      if (mic_s2_q == lvl_q) begin
        stab_q <= '0;
      end else if (ce_3m25) begin
        if (acc_w) begin
          lvl_q  <= ~lvl_q;
          stab_q <= '0;
        end else begin
          stab_q <= stab_q + 16'd1;
        end
      end
      if (acc_w) phase_q <= '0;
      else if (ce_3m25 && phase_q != 16'hFFFF) phase_q <= phase_q + 16'd1;
    end
  end

  assign bit_val_w = (pulse_q > ZMAX_C);
  assign bit_ok_w  = (pulse_q <= OMAX_C);
  assign byte_d    = {sr_q[6:0], bit_val_w};

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pulse_q     <= '0;
      sr_q        <= '0;
      bitcnt_q    <= '0;
      wptr_q      <= '0;
      name_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_dat_q    <= '0;
      save_size   <= '0;
      save_active <= 1'b0;
      save_done   <= 1'b0;
      save_err    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arm && rise_w) begin
            state_q     <= ST_HIGH;
            wptr_q      <= '0;
            pulse_q     <= '0;
            bitcnt_q    <= '0;
            save_done   <= 1'b0;
            save_err    <= 1'b0;
            name_q      <= strip_name;
            save_active <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (fall_w) begin
            if (pulse_q != 4'hF) pulse_q <= pulse_q + 4'd1;
            state_q <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (rise_w) begin
            state_q <= ST_HIGH;
          end else if (phase_q >= GAPB_C) begin
            pulse_q <= '0;
            state_q <= ST_GAP;
            if (!bit_ok_w) begin
              save_err <= 1'b1;
            end else begin
              sr_q     <= byte_d;
              bitcnt_q <= bitcnt_q + 3'd1;
              if (bitcnt_q == 3'd7) begin
                // Name bytes end at the first one carrying the bit7 terminator.
                if (name_q) begin
                  if (byte_d[7]) name_q <= 1'b0;
                end else if (wptr_q < DEPTH_C) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= wptr_q[AW-1:0];
                  wr_dat_q  <= byte_d;
                  wptr_q    <= wptr_q + WPTR_ONE;
                end else begin
                  save_err <= 1'b1;
                end
              end
            end
          end
        end
        ST_GAP: begin
          if (rise_w) begin
            state_q <= ST_HIGH;
          end else if (phase_q >= GAPE_C) begin
            state_q     <= ST_IDLE;
            save_active <= 1'b0;
            save_done   <= 1'b1;
            save_size   <= (wptr_q >= DEPTH_C) ? SIZE_SAT : 14'(wptr_q[AW-1:0]);
            if (bitcnt_q != 3'd0) save_err <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  zx81_tape_saver_buf #(.AW(AW)) u_buf (
    .clk_sys   (clk_sys),
    .wr_en_i   (wr_en_q),
    .wr_addr_i (wr_addr_q),
    .wr_dat_i  (wr_dat_q),
    .rd_addr_i (ioctl_addr[AW-1:0]),
    .rd_dat_o  (ioctl_din)
  );

endmodule

// File: doc/zx81_tape_saver.md
# zx81_tape_saver

- Decodes the ZX81 SAVE pulse stream on the MIC line into bytes and stores them in an internal 16 KB buffer.
- The stored image is uploaded to the host as a .p file through the ioctl read port.
- Sits beside the fast tape loader in the ZX81 glue and is the write side of the same cassette format: the loader feeds bytes to the CPU, this block captures what the CPU saves.
- Owns pulse measurement, bit and byte assembly, name stripping, length tracking and the buffer.

## Interface
Parameters (all counts are ce_3m25 ticks):
- PULSE_MIN, 64: minimum high or low phase length accepted as a real edge (~20 µs glitch filter).
- GAP_BIT, 2000: low time that terminates a bit (~615 µs).
- GAP_END, 32500: low time that terminates the file (~10 ms).
- ZERO_MAX, 6: pulse count at or below which a bit decodes as 0.
- ONE_MAX, 12: pulse count at or below which a bit decodes as 1.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ce_3m25  in  1  3.25 MHz clock enable; all counters advance only on it.
- mic  in  1  raw MIC output from the CPU side (high = pulse), asynchronous to the decode timing.
- arm  in  1  level; while high, a new capture may start from IDLE.
- strip_name  in  1  when 1, discard the program name (bytes up to and including the first byte with bit7 = 1).
- ioctl_addr  in  14  upload read address.
- ioctl_din  out  8  buffer byte at ioctl_addr, one-cycle read latency.
- save_size  out  14  number of bytes stored in the last completed capture.
- save_active  out  1  capture in progress.
- save_done  out  1  sticky; set at end of file, cleared on the next capture start.
- save_err  out  1  sticky; set on a malformed bit or on overflow, cleared on the next capture start.

## Operation
- Input conditioning: mic goes through a 2-FF synchroniser. A level change is accepted only after the new level has been stable for PULSE_MIN ticks.
- Phase counter: 16-bit, saturating, cleared on every accepted edge.
- Pulse counter: 4-bit, saturating at 15.
- Bit shift register: 8 bits, MSB first; bit counter is 3 bits.
- Write pointer: 15 bits, so overflow can be detected.

State machine:
- IDLE: wait for arm and an accepted rising edge, then go to HIGH. On entry to a capture:
  - wptr = 0, pulse count = 0, bit count = 0;
  - save_done = 0, save_err = 0, name phase = strip_name, save_active = 1.
- HIGH: on an accepted falling edge, pulse count += 1 and go to LOW.
- LOW:
  - Accepted rising edge before GAP_BIT: go to HIGH (same bit).
  - Phase counter reaches GAP_BIT: decode the pulse count.
    - Count ≤ ZERO_MAX: bit 0.
    - Count ≤ ONE_MAX: bit 1.
    - Otherwise: set save_err and drop the bit; the bit counter does not advance.
  - Then clear the pulse count and go to GAP.
- GAP:
  - Accepted rising edge: go to HIGH (next bit).
  - Phase counter reaches GAP_END: go to IDLE and finish the file.
- Byte complete (8th bit shifted in), depending on name phase:
  - Name phase: discard the byte; if its bit7 = 1, leave name phase.
  - Otherwise, with wptr < 16384: write the byte to buffer[wptr] and increment wptr.
  - Otherwise (wptr ≥ 16384): set save_err and drop the byte.
- End of file:
  - save_size = wptr[13:0], saturated to 16383 on overflow.
  - save_done = 1, save_active = 0.
  - A partial byte (bit count ≠ 0) is discarded and sets save_err.
- arm deasserted mid-capture: the capture continues to end of file; arm only gates the start.
- A pulse count of 0 is not possible at decode; only an accepted falling edge increments the count.

## Timing
- Reset values: save_size = 0, save_active = 0, save_done = 0, save_err = 0, FSM = IDLE, all counters = 0.
- ioctl_din is registered. The buffer contents are not reset.
- Edge acceptance latency: 2 clk_sys cycles plus PULSE_MIN ticks.
- Buffer write: the clk_sys cycle after the 8th bit decodes.
- save_done rises on the same clk_sys edge that returns the FSM to IDLE; save_size is valid on that edge.
- If an upload read and an internal write hit the same address in the same cycle, the read returns the old data.
- Reset asserted mid-capture: the FSM returns to IDLE immediately; already-written bytes stay in the buffer but save_size = 0.

## Structure
- zx81_tape_pkg holds:
  - the state enum (IDLE, HIGH, LOW, GAP);
  - BUF_DEPTH = 16384;
  - the default tick constants.
- zx81_tape_saver_buf is a single sub-module: a simple dual-port 16K × 8 RAM with a write port on decode and a read port on ioctl.

## Test plan
- Send byte 0xA5 as 4/9-pulse bits (150 µs high, 150 µs low, 1300 µs gap) with strip_name = 0, then 10 ms of silence:
  - buffer[0] = 0xA5, save_size = 1, save_done = 1, save_err = 0.
- strip_name = 1, send name bytes 0x26, 0xB8, then data bytes 0x00, 0x7F, then end:
  - buffer = 00 7F, save_size = 2.
- Inject a 10 µs high glitch inside a LOW phase and a bit with 15 pulses:
  - glitch ignored;
  - the 15-pulse bit sets save_err and is dropped; the following bits decode correctly.
- Stream 16385 bytes:
  - save_size = 16383, save_err = 1, buffer[16383] = the last accepted byte.
- Assert reset after 3 bits of a byte:
  - outputs return to their reset values;
  - a subsequent full capture of 0x3C gives save_size = 1 and buffer[0] = 0x3C.
- End a file after 5 bits:
  - save_err = 1, the partial byte is not written, save_done = 1.
